// File: rtl/ysyx_22040750_trap_ctrl_pkg.sv
// Shared encodings for the trap sequencer: FSM states, trap kind and mcause values.
package ysyx_22040750_trap_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFlush = 3'd1,
        StDrain = 3'd2,
        StWrite = 3'd3,
        StRedir = 3'd4
    } state_e;

    typedef enum logic {
        KindTrap = 1'b0,
        KindMret = 1'b1
    } kind_e;

    localparam logic [63:0] CauseEcallM = 64'd11;
    localparam logic [63:0] CauseMtimer = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_22040750_trap_ctrl.sv
// Trap sequencer: ecall/mret/timer -> flush, drain, CSR update, fetch redirect.
// Optional TRAP_CNT_EN adds a 32-bit trap-entry counter on O_trap_cnt.
module ysyx_22040750_trap_ctrl
    import ysyx_22040750_trap_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = 32,
    parameter int unsigned XLEN = 64
) (
    input  logic            I_sys_clk,
    input  logic            I_rst_n,
    input  logic            I_commit_valid,
    input  logic [PC_W-1:0] I_commit_pc,
    input  logic            I_ecall_commit,
    input  logic            I_mret_commit,
    input  logic            I_timer_intr,
    input  logic            I_pipe_empty,
    input  logic [XLEN-1:0] I_csr_rd_data,
    input  logic            I_redirect_ready,
    output logic            O_flush,
    output logic            O_stall_fetch,
    output logic            O_csr_wr_valid,
    output logic            O_csr_intr_wr,
    output logic            O_csr_intr_rd,
    output logic            O_csr_mret_wr,
    output logic            O_csr_mret_rd,
    output logic [PC_W-1:0] O_intr_pc,
    output logic [XLEN-1:0] O_intr_no,
    output logic            O_redirect_valid,
    output logic [PC_W-1:0] O_redirect_pc,
    output logic [31:0]     O_trap_cnt
);

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [XLEN-1:0] cause_q, cause_d;

    logic accept;
    assign accept = (state_q == StIdle) && I_commit_valid &&
                    (I_mret_commit || I_ecall_commit || I_timer_intr);

    // Only the aligned PC slice of the CSR read is used as a target.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{I_csr_rd_data[XLEN-1:PC_W], I_csr_rd_data[1:0]};

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StFlush;
            StFlush: state_d = StDrain;
            StDrain: if (I_pipe_empty) state_d = StWrite;
            StWrite: state_d = StRedir;
            StRedir: if (I_redirect_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        kind_d   = kind_q;
        pc_d     = pc_q;
        cause_d  = cause_q;
        target_d = target_q;
        if (accept) begin
            if (I_mret_commit) begin
                kind_d = KindMret;
            end else if (I_ecall_commit) begin
                kind_d  = KindTrap;
                pc_d    = I_commit_pc;
                cause_d = XLEN'(CauseEcallM);
            end else begin
                // Interrupt is taken after the retiring instruction.
                kind_d  = KindTrap;
                pc_d    = I_commit_pc + PC_W'(4);
                cause_d = XLEN'(CauseMtimer);
            end
        end
        if (state_q == StWrite) begin
            target_d = {I_csr_rd_data[PC_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            kind_q   <= KindTrap;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            kind_q   <= kind_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        O_flush          = (state_q == StFlush);
        O_stall_fetch    = (state_q != StIdle);
        O_csr_wr_valid   = (state_q == StWrite);
        O_csr_intr_wr    = (state_q == StWrite) && (kind_q == KindTrap);
        O_csr_intr_rd    = O_csr_intr_wr;
        O_csr_mret_wr    = (state_q == StWrite) && (kind_q == KindMret);
        O_csr_mret_rd    = O_csr_mret_wr;
        O_intr_pc        = O_csr_intr_wr ? pc_q : '0;
        O_intr_no        = O_csr_intr_wr ? cause_q : '0;
        O_redirect_valid = (state_q == StRedir);
        O_redirect_pc    = (state_q == StRedir) ? target_q : '0;
    end

`ifdef TRAP_CNT_EN
    logic [31:0] trap_cnt_q;

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            trap_cnt_q <= '0;
        end else if ((state_q == StWrite) && (kind_q == KindTrap)) begin
            trap_cnt_q <= trap_cnt_q + 32'd1;
        end
    end

    assign O_trap_cnt = trap_cnt_q;
`else
    assign O_trap_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// Directed table-driven bench for the trap sequencer, plus reset and counter corner cases.
module tb_ysyx_22040750_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        ecall_commit;
    logic        mret_commit;
    logic        timer_intr;
    logic        pipe_empty;
    logic [63:0] csr_rd_data;
    logic        redirect_ready;
    logic        flush, stall_fetch, csr_wr_valid, csr_intr_wr, csr_intr_rd;
    logic        csr_mret_wr, csr_mret_rd, redirect_valid;
    logic [31:0] intr_pc, redirect_pc, trap_cnt;
    logic [63:0] intr_no;

    int checks = 0;
    int errors = 0;

    ysyx_22040750_trap_ctrl dut (
        .I_sys_clk        (clk),
        .I_rst_n          (rst_n),
        .I_commit_valid   (commit_valid),
        .I_commit_pc      (commit_pc),
        .I_ecall_commit   (ecall_commit),
        .I_mret_commit    (mret_commit),
        .I_timer_intr     (timer_intr),
        .I_pipe_empty     (pipe_empty),
        .I_csr_rd_data    (csr_rd_data),
        .I_redirect_ready (redirect_ready),
        .O_flush          (flush),
        .O_stall_fetch    (stall_fetch),
        .O_csr_wr_valid   (csr_wr_valid),
        .O_csr_intr_wr    (csr_intr_wr),
        .O_csr_intr_rd    (csr_intr_rd),
        .O_csr_mret_wr    (csr_mret_wr),
        .O_csr_mret_rd    (csr_mret_rd),
        .O_intr_pc        (intr_pc),
        .O_intr_no        (intr_no),
        .O_redirect_valid (redirect_valid),
        .O_redirect_pc    (redirect_pc),
        .O_trap_cnt       (trap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {flush, stall, wr_valid, intr_wr, intr_rd, mret_wr, mret_rd, redirect_valid}
    localparam logic [7:0] FI  = 8'b0000_0000;
    localparam logic [7:0] FF  = 8'b1100_0000;
    localparam logic [7:0] FD  = 8'b0100_0000;
    localparam logic [7:0] FWT = 8'b0111_1000;
    localparam logic [7:0] FWM = 8'b0110_0110;
    localparam logic [7:0] FR  = 8'b0100_0001;
    localparam logic [63:0] MTIMER = 64'h8000_0000_0000_0007;

    typedef struct {
        logic        cv;
        logic [31:0] pc;
        logic        ec;
        logic        mr;
        logic        tm;
        logic        pe;
        logic [63:0] rd;
        logic        rdy;
        logic [7:0]  ef;
        logic [31:0] eipc;
        logic [63:0] eino;
        logic [31:0] erpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic cv, logic [31:0] pc, logic ec, logic mr, logic tm,
                                logic pe, logic [63:0] rd, logic rdy, logic [7:0] ef,
                                logic [31:0] eipc, logic [63:0] eino, logic [31:0] erpc);
        vec_t v;
        v.cv = cv; v.pc = pc; v.ec = ec; v.mr = mr; v.tm = tm; v.pe = pe; v.rd = rd;
        v.rdy = rdy; v.ef = ef; v.eipc = eipc; v.eino = eino; v.erpc = erpc;
        return v;
    endfunction

    task automatic check_outs(string name, logic [7:0] ef, logic [31:0] eipc,
                              logic [63:0] eino, logic [31:0] erpc);
        logic [7:0] af;
        af = {flush, stall_fetch, csr_wr_valid, csr_intr_wr, csr_intr_rd,
              csr_mret_wr, csr_mret_rd, redirect_valid};
        checks++;
        if (af !== ef || intr_pc !== eipc || intr_no !== eino || redirect_pc !== erpc) begin
            errors++;
            $display("FAIL %s: got flags=%b ipc=%h ino=%h rpc=%h, want flags=%b ipc=%h ino=%h rpc=%h",
                     name, af, intr_pc, intr_no, redirect_pc, ef, eipc, eino, erpc);
        end
    endtask

    task automatic check_cnt(string name, logic [31:0] exp_cnt);
        checks++;
        if (trap_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s: got trap_cnt=%h, want %h", name, trap_cnt, exp_cnt);
        end
    endtask

    task automatic apply(vec_t v, string name);
        @(negedge clk);
        commit_valid   = v.cv;
        commit_pc      = v.pc;
        ecall_commit   = v.ec;
        mret_commit    = v.mr;
        timer_intr     = v.tm;
        pipe_empty     = v.pe;
        csr_rd_data    = v.rd;
        redirect_ready = v.rdy;
        #1;
        check_outs(name, v.ef, v.eipc, v.eino, v.erpc);
    endtask

    task automatic ecall_seq(logic [31:0] pc, logic [63:0] rd, string name);
        apply(mk(1, pc, 1, 0, 0, 1, rd, 1, FI, 0, 0, 0), name);
        apply(mk(0, 0, 0, 0, 0, 1, rd, 1, FF, 0, 0, 0), name);
        apply(mk(0, 0, 0, 0, 0, 1, rd, 1, FD, 0, 0, 0), name);
        apply(mk(0, 0, 0, 0, 0, 1, rd, 1, FWT, pc, 64'd11, 0), name);
        apply(mk(0, 0, 0, 0, 0, 1, rd, 1, FR, 0, 0, {rd[31:2], 2'b00}), name);
    endtask

    initial begin
        rst_n = 1'b0;
        commit_valid = 0; commit_pc = 0; ecall_commit = 0; mret_commit = 0;
        timer_intr = 0; pipe_empty = 0; csr_rd_data = 0; redirect_ready = 0;

        // ecall, single-cycle drain
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, FI, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0010, 1, 0, 0, 1, 64'h8000_0100, 1, FI, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0100, 1, FF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0100, 1, FD, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0100, 1, FWT, 32'h8000_0010, 64'd11, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0100, 1, FR, 0, 0, 32'h8000_0100));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0100, 1, FI, 0, 0, 0));
        // timer, misaligned mtvec, then level without commit must wait
        vecs.push_back(mk(1, 32'h8000_0020, 0, 0, 1, 1, 64'h8000_0103, 1, FI, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h8000_0103, 1, FF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h8000_0103, 1, FD, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h8000_0103, 1, FWT, 32'h8000_0024, MTIMER, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h8000_0103, 1, FR, 0, 0, 32'h8000_0100));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, FI, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, FI, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, FI, 0, 0, 0));
        // mret beats ecall; ecall during DRAIN is ignored
        vecs.push_back(mk(1, 32'h8000_0060, 1, 1, 0, 1, 64'h8000_0044, 1, FI, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0044, 1, FF, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0064, 1, 0, 0, 1, 64'h8000_0044, 1, FD, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0044, 1, FWM, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0044, 1, FR, 0, 0, 32'h8000_0044));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0044, 1, FI, 0, 0, 0));
        // ecall+timer together, slow drain, slow redirect, then timer on next commit
        vecs.push_back(mk(1, 32'h8000_0030, 1, 0, 1, 0, 0, 0, FI, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, FF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, FD, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, FD, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, FD, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, FD, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h8000_0200, 0, FWT, 32'h8000_0030, 64'd11, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, FR, 0, 0, 32'h8000_0200));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, FR, 0, 0, 32'h8000_0200));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, FR, 0, 0, 32'h8000_0200));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, FI, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0040, 0, 0, 1, 1, 64'h8000_0200, 1, FI, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h8000_0200, 1, FF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h8000_0200, 1, FD, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h8000_0200, 1, FWT, 32'h8000_0044, MTIMER, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h8000_0200, 1, FR, 0, 0, 32'h8000_0200));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, FI, 0, 0, 0));

        repeat (3) @(negedge clk);
        #1;
        check_outs("reset_outputs", FI, 0, 0, 0);
        check_cnt("reset_cnt", 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef TRAP_CNT_EN
        check_cnt("cnt_after_table", 32'd4);
        force dut.trap_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.trap_cnt_q;
        check_cnt("cnt_preload", 32'hFFFF_FFFF);
        ecall_seq(32'h8000_0070, 64'h8000_0100, "cnt_wrap_seq");
        check_cnt("cnt_wrap", 32'd0);
`else
        check_cnt("cnt_tied_off", 32'd0);
`endif

        // reset while draining
        apply(mk(1, 32'h8000_0050, 1, 0, 0, 0, 0, 0, FI, 0, 0, 0), "rd_accept");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, FF, 0, 0, 0), "rd_flush");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, FD, 0, 0, 0), "rd_drain");
        #1 rst_n = 1'b0;
        #1 check_outs("rst_in_drain", FI, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 1, 64'h8000_0300, 1, FI, 0, 0, 0), "rd_idle_after");
        apply(mk(0, 0, 0, 0, 0, 1, 64'h8000_0300, 1, FI, 0, 0, 0), "rd_no_write");

        // reset while redirect is held
        apply(mk(1, 32'h8000_0080, 1, 0, 0, 1, 64'h8000_0300, 0, FI, 0, 0, 0), "rr_accept");
        apply(mk(0, 0, 0, 0, 0, 1, 64'h8000_0300, 0, FF, 0, 0, 0), "rr_flush");
        apply(mk(0, 0, 0, 0, 0, 1, 64'h8000_0300, 0, FD, 0, 0, 0), "rr_drain");
        apply(mk(0, 0, 0, 0, 0, 1, 64'h8000_0300, 0, FWT, 32'h8000_0080, 64'd11, 0), "rr_write");
        apply(mk(0, 0, 0, 0, 0, 1, 64'h8000_0300, 0, FR, 0, 0, 32'h8000_0300), "rr_redir");
        #1 rst_n = 1'b0;
        #1 check_outs("rst_in_redir", FI, 0, 0, 0);
        check_cnt("rst_cnt_clear", 32'd0);
        @(negedge clk) rst_n = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, FI, 0, 0, 0), "rr_idle_after");
        ecall_seq(32'h8000_0090, 64'h8000_0400, "post_reset_ecall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
